// File: rtl/rd_active_vertex_offset_ctrl_if.sv
// Bus bundle between the active-vertex scheduler, this stage and the offset/value BRAM read stage.
// Width defaults come from the project-wide V_ID_WIDTH / ITERATION_WIDTH / ... macros when defined.
`ifndef V_ID_WIDTH
`define V_ID_WIDTH 32
`endif
`ifndef ITERATION_WIDTH
`define ITERATION_WIDTH 8
`endif
`ifndef V_OFF_AWIDTH
`define V_OFF_AWIDTH 16
`endif
`ifndef DELTA_BRAM_AWIDTH
`define DELTA_BRAM_AWIDTH 16
`endif

interface rd_active_vertex_offset_ctrl_if #(
   parameter int V_ID_WIDTH        = `V_ID_WIDTH,
   parameter int ITERATION_WIDTH   = `ITERATION_WIDTH,
   parameter int V_OFF_AWIDTH      = `V_OFF_AWIDTH,
   parameter int DELTA_BRAM_AWIDTH = `DELTA_BRAM_AWIDTH,
   parameter int FIFO_AWIDTH       = 5
);
   logic [V_ID_WIDTH-1:0]        front_active_v_id;
   logic                         front_active_v_valid;
   logic                         front_iteration_end;
   logic                         front_iteration_end_valid;
   logic [ITERATION_WIDTH-1:0]   front_iteration_id;
   logic                         next_stage_full;
   logic                         stage_full;
   logic [V_ID_WIDTH-1:0]        active_v_id;
   logic                         active_v_id_valid;
   logic [V_OFF_AWIDTH-1:0]      rd_active_v_offset_addr;
   logic [DELTA_BRAM_AWIDTH-1:0] rd_active_v_value_addr;
   logic                         rd_active_v_addr_valid;
   logic                         iteration_end;
   logic                         iteration_end_valid;
   logic [ITERATION_WIDTH-1:0]   iteration_id;
   logic [FIFO_AWIDTH:0]         fifo_level;
   logic                         overflow_err;

   modport master (
      output front_active_v_id, front_active_v_valid, front_iteration_end,
             front_iteration_end_valid, front_iteration_id, next_stage_full,
      input  stage_full, active_v_id, active_v_id_valid, rd_active_v_offset_addr,
             rd_active_v_value_addr, rd_active_v_addr_valid, iteration_end,
             iteration_end_valid, iteration_id, fifo_level, overflow_err
   );

   modport slave (
      input  front_active_v_id, front_active_v_valid, front_iteration_end,
             front_iteration_end_valid, front_iteration_id, next_stage_full,
      output stage_full, active_v_id, active_v_id_valid, rd_active_v_offset_addr,
             rd_active_v_value_addr, rd_active_v_addr_valid, iteration_end,
             iteration_end_valid, iteration_id, fifo_level, overflow_err
   );
endinterface

// File: rtl/rd_active_vertex_offset_ctrl.sv
// Per-core active-vertex FIFO stage emitting BRAM read addresses, with end-of-iteration detection.
// Define RD_AVO_DUP_FILTER_EN to drop writes repeating the last accepted vertex ID.
//
// state   | meaning
// IDLE    | end condition not seen (or aborted by iteration change)
// WAIT    | end condition stable, drain-delay down-counter running
// DONE    | end condition held long enough; iteration_end asserted
`ifndef V_ID_WIDTH
`define V_ID_WIDTH 32
`endif
`ifndef ITERATION_WIDTH
`define ITERATION_WIDTH 8
`endif
`ifndef V_OFF_AWIDTH
`define V_OFF_AWIDTH 16
`endif
`ifndef DELTA_BRAM_AWIDTH
`define DELTA_BRAM_AWIDTH 16
`endif
`ifndef CORE_NUM_WIDTH
`define CORE_NUM_WIDTH 5
`endif
`ifndef WAIT_END_DELAY
`define WAIT_END_DELAY 20
`endif

module rd_active_vertex_offset_ctrl #(
   parameter int V_ID_WIDTH        = `V_ID_WIDTH,
   parameter int ITERATION_WIDTH   = `ITERATION_WIDTH,
   parameter int V_OFF_AWIDTH      = `V_OFF_AWIDTH,
   parameter int DELTA_BRAM_AWIDTH = `DELTA_BRAM_AWIDTH,
   parameter int CORE_NUM_WIDTH    = `CORE_NUM_WIDTH,
   parameter int FIFO_AWIDTH       = 5,
   parameter int PROG_FULL_THRESH  = 24,
   parameter int WAIT_END_DELAY    = `WAIT_END_DELAY
) (
   input logic clk,
   input logic rst,
   rd_active_vertex_offset_ctrl_if.slave bus
);
   localparam int DEPTH = 1 << FIFO_AWIDTH;
   localparam int CNT_W = (WAIT_END_DELAY > 1) ? $clog2(WAIT_END_DELAY) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   logic [V_ID_WIDTH-1:0]      mem [DEPTH];
   logic [FIFO_AWIDTH-1:0]     wr_ptr;
   logic [FIFO_AWIDTH-1:0]     rd_ptr;
   logic [FIFO_AWIDTH:0]       level;
   logic [V_ID_WIDTH-1:0]      head_id;
   logic                       head_valid;
   logic                       stage_full_q;
   logic                       ovf_q;
   logic [ITERATION_WIDTH-1:0] iter_q;
   state_t                     state;
   logic [CNT_W-1:0]           cnt;
   logic                       end_q;

   logic rd_en;
   logic wr_room;
   logic wr_en;
   logic dup_hit;
   logic iter_chg;
   logic end_cond;

   assign iter_chg = bus.front_iteration_id != iter_q;
   assign rd_en    = !bus.next_stage_full && (level != '0);
   // A pop in the same cycle frees the slot, so a full FIFO can still take a write.
   assign wr_room  = (level < (FIFO_AWIDTH+1)'(DEPTH)) || rd_en;
   assign wr_en    = bus.front_active_v_valid && !dup_hit && wr_room;
   assign end_cond = bus.front_iteration_end && bus.front_iteration_end_valid &&
                     (level == '0) && !head_valid;

`ifdef RD_AVO_DUP_FILTER_EN
   logic [V_ID_WIDTH-1:0] last_id;
   logic                  last_ok;

   assign dup_hit = last_ok && !iter_chg && (bus.front_active_v_id == last_id);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_id <= '0;
         last_ok <= 1'b0;
      end else if (wr_en) begin
         last_id <= bus.front_active_v_id;
         last_ok <= 1'b1;
      end else if (iter_chg) begin
         last_ok <= 1'b0;
      end
   end
`else
   assign dup_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= bus.front_active_v_id;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         head_id      <= '0;
         head_valid   <= 1'b0;
         stage_full_q <= 1'b0;
         ovf_q        <= 1'b0;
         iter_q       <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) begin
            rd_ptr  <= rd_ptr + 1'b1;
            head_id <= mem[rd_ptr];
         end
         head_valid <= rd_en;
         case ({wr_en, rd_en})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         stage_full_q <= level >= (FIFO_AWIDTH+1)'(PROG_FULL_THRESH);
         if (bus.front_active_v_valid && !dup_hit && !wr_room) ovf_q <= 1'b1;
         iter_q <= bus.front_iteration_id;
      end
   end

   // Drain delay: load WAIT_END_DELAY-1 on entry, DONE at terminal count with C still high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         end_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               end_q <= 1'b0;
               if (end_cond) begin
                  state <= ST_WAIT;
                  cnt   <= CNT_W'(WAIT_END_DELAY - 1);
               end
            end
            ST_WAIT: begin
               if (!end_cond || iter_chg) begin
                  state <= ST_IDLE;
               end else if (cnt == '0) begin
                  state <= ST_DONE;
                  end_q <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               if (!end_cond || iter_chg) begin
                  state <= ST_IDLE;
                  end_q <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               end_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.stage_full              = stage_full_q;
   assign bus.active_v_id             = head_id;
   assign bus.active_v_id_valid       = head_valid;
   assign bus.rd_active_v_offset_addr = V_OFF_AWIDTH'(head_id >> CORE_NUM_WIDTH);
   assign bus.rd_active_v_value_addr  = DELTA_BRAM_AWIDTH'(head_id >> CORE_NUM_WIDTH);
   assign bus.rd_active_v_addr_valid  = head_valid;
   assign bus.iteration_end           = end_q;
   assign bus.iteration_end_valid     = end_q;
   assign bus.iteration_id            = iter_q;
   assign bus.fifo_level              = level;
   assign bus.overflow_err            = ovf_q;
endmodule

// File: tb/tb_rd_active_vertex_offset_ctrl.sv
// Self-checking bench: constant vector table, hand sequences for full/end/reset corners,
// and a random run against a queue-based reference model.
module tb_rd_active_vertex_offset_ctrl;
   localparam int VW    = 32;
   localparam int IW    = 8;
   localparam int OW    = 16;
   localparam int DW    = 16;
   localparam int CW    = 5;
   localparam int AW    = 5;
   localparam int DEPTH = 32;
   localparam int THR   = 24;
   localparam int DLY   = 20;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rd_active_vertex_offset_ctrl_if #(
      .V_ID_WIDTH(VW), .ITERATION_WIDTH(IW), .V_OFF_AWIDTH(OW),
      .DELTA_BRAM_AWIDTH(DW), .FIFO_AWIDTH(AW)
   ) bus ();

   rd_active_vertex_offset_ctrl #(
      .V_ID_WIDTH(VW), .ITERATION_WIDTH(IW), .V_OFF_AWIDTH(OW),
      .DELTA_BRAM_AWIDTH(DW), .CORE_NUM_WIDTH(CW), .FIFO_AWIDTH(AW),
      .PROG_FULL_THRESH(THR), .WAIT_END_DELAY(DLY)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: FIFO contents as a queue, end detection as a run length of C.
   logic [VW-1:0] q[$];
   bit            m_valid;
   logic [VW-1:0] m_id;
   bit            m_sf;
   bit            m_ovf;
   bit            m_end;
   int            streak;
   logic [IW-1:0] m_iter;
   logic [VW-1:0] m_last;
   bit            m_last_ok;

   task automatic model_reset();
      q.delete();
      m_valid = 0; m_id = '0; m_sf = 0; m_ovf = 0; m_end = 0;
      streak = 0; m_iter = '0; m_last = '0; m_last_ok = 0;
   endtask

   task automatic step();
      int sz;
      bit rd, wr, c, chg, dup, room;
      sz   = q.size();
      rd   = !bus.next_stage_full && sz != 0;
      c    = bus.front_iteration_end && bus.front_iteration_end_valid && sz == 0 && !m_valid;
      chg  = bus.front_iteration_id != m_iter;
      dup  = 0;
`ifdef RD_AVO_DUP_FILTER_EN
      dup  = m_last_ok && !chg && bus.front_active_v_id == m_last;
`endif
      room = sz < DEPTH || rd;
      wr   = bus.front_active_v_valid && !dup && room;
      if (bus.front_active_v_valid && !dup && !room) m_ovf = 1;
      m_sf = sz >= THR;
      if (rd) m_id = q.pop_front();
      m_valid = rd;
      if (wr) q.push_back(bus.front_active_v_id);
      if (wr) begin
         m_last = bus.front_active_v_id;
         m_last_ok = 1;
      end else if (chg) begin
         m_last_ok = 0;
      end
      if (streak > 0 && chg) streak = 0;
      else if (c)            streak++;
      else                   streak = 0;
      m_end  = streak >= DLY + 1;
      m_iter = bus.front_iteration_id;
      @(posedge clk);
      #1;
      chk("m_valid",  bus.active_v_id_valid, m_valid);
      chk("m_id",     bus.active_v_id, m_id);
      chk("m_offaddr", bus.rd_active_v_offset_addr, OW'(m_id >> CW));
      chk("m_valaddr", bus.rd_active_v_value_addr, DW'(m_id >> CW));
      chk("m_addrv",  bus.rd_active_v_addr_valid, m_valid);
      chk("m_level",  bus.fifo_level, q.size());
      chk("m_sfull",  bus.stage_full, m_sf);
      chk("m_ovf",    bus.overflow_err, m_ovf);
      chk("m_end",    bus.iteration_end, m_end);
      chk("m_endv",   bus.iteration_end_valid, m_end);
      chk("m_iter",   bus.iteration_id, m_iter);
   endtask

   // Asserts reset asynchronously, checks cleared outputs before any edge, releases at negedge.
   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      #1;
      chk("rst_level", bus.fifo_level, 0);
      chk("rst_valid", bus.active_v_id_valid, 0);
      chk("rst_id",    bus.active_v_id, 0);
      chk("rst_addr",  bus.rd_active_v_offset_addr, 0);
      chk("rst_sfull", bus.stage_full, 0);
      chk("rst_ovf",   bus.overflow_err, 0);
      chk("rst_endv",  bus.iteration_end_valid, 0);
      chk("rst_iter",  bus.iteration_id, 0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic idle_inputs();
      bus.front_active_v_valid      = 1'b0;
      bus.front_active_v_id         = '0;
      bus.front_iteration_end       = 1'b0;
      bus.front_iteration_end_valid = 1'b0;
      bus.next_stage_full           = 1'b0;
   endtask

   typedef struct {
      bit            v;
      logic [VW-1:0] id;
      bit            nsf;
      bit            e_valid;
      logic [VW-1:0] e_id;
      int            e_level;
      logic [OW-1:0] e_addr;
   } vec_t;

   initial begin
      vec_t tbl[9];
      int   got;
      logic [VW-1:0] outs[$];

      // Record k drives cycle k; expectations are the outputs seen in cycle k+1.
      tbl[0] = '{1, 32'h020, 0, 0, 32'h000, 1, 16'h00};
      tbl[1] = '{1, 32'h041, 0, 1, 32'h020, 1, 16'h01};
      tbl[2] = '{1, 32'h7E5, 0, 1, 32'h041, 1, 16'h02};
      tbl[3] = '{0, 32'h000, 0, 1, 32'h7E5, 0, 16'h3F};
      tbl[4] = '{0, 32'h000, 0, 0, 32'h7E5, 0, 16'h3F};
      tbl[5] = '{1, 32'h100, 1, 0, 32'h7E5, 1, 16'h3F};
      tbl[6] = '{0, 32'h000, 1, 0, 32'h7E5, 1, 16'h3F};
      tbl[7] = '{0, 32'h000, 0, 1, 32'h100, 0, 16'h08};
      tbl[8] = '{0, 32'h000, 0, 0, 32'h100, 0, 16'h08};

      idle_inputs();
      bus.front_iteration_id = '0;
      #3;
      do_reset();

      for (int k = 0; k < 9; k++) begin
         bus.front_active_v_valid = tbl[k].v;
         bus.front_active_v_id    = tbl[k].id;
         bus.next_stage_full      = tbl[k].nsf;
         step();
         chk("tbl_valid", bus.active_v_id_valid, tbl[k].e_valid);
         chk("tbl_id",    bus.active_v_id, tbl[k].e_id);
         chk("tbl_level", bus.fifo_level, tbl[k].e_level);
         chk("tbl_addr",  bus.rd_active_v_offset_addr, tbl[k].e_addr);
      end

      // Fill past depth under back-pressure, then drain.
      idle_inputs();
      do_reset();
      bus.next_stage_full = 1'b1;
      for (int i = 1; i <= DEPTH + 1; i++) begin
         bus.front_active_v_valid = 1'b1;
         bus.front_active_v_id    = 32'h1000 + i;
         step();
         chk("full_level", bus.fifo_level, (i <= DEPTH) ? i : DEPTH);
         chk("full_sfull", bus.stage_full, (i - 1) >= THR);
         chk("full_ovf",   bus.overflow_err, i > DEPTH);
      end
      bus.front_active_v_valid = 1'b0;
      bus.next_stage_full      = 1'b0;
      got = 0;
      for (int n = 0; n < 60; n++) begin
         step();
         if (bus.active_v_id_valid) begin
            chk("drain_id", bus.active_v_id, 32'h1000 + got + 1);
            got++;
         end
      end
      chk("drain_count", got, DEPTH);
      chk("drain_ovf_sticky", bus.overflow_err, 1);

      // End detection with C held from cycle 0, dropped at cycle 30.
      idle_inputs();
      bus.front_iteration_id = 8'h03;
      do_reset();
      bus.front_iteration_end       = 1'b1;
      bus.front_iteration_end_valid = 1'b1;
      for (int k = 0; k < 30; k++) begin
         step();
         chk("end_hold", bus.iteration_end_valid, (k + 1) >= DLY + 1);
      end
      bus.front_iteration_end = 1'b0;
      step();
      chk("end_drop", bus.iteration_end_valid, 0);
      step();

      // Abort: iteration changes 10 cycles into WAIT.
      bus.front_iteration_end = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (k == 11) bus.front_iteration_id = 8'h04;
         step();
         chk("abort_end", bus.iteration_end, (k + 1) >= 11 + DLY + 2);
      end
      idle_inputs();
      step();

      // Asynchronous reset with 5 entries queued and a live head.
      do_reset();
      bus.front_iteration_id = 8'h05;
      bus.next_stage_full    = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         bus.front_active_v_valid = 1'b1;
         bus.front_active_v_id    = 32'h200 + i;
         step();
      end
      bus.front_active_v_valid = 1'b0;
      bus.next_stage_full      = 1'b0;
      step();
      bus.front_active_v_valid = 1'b1;
      bus.front_active_v_id    = 32'h206;
      bus.next_stage_full      = 1'b1;
      step();
      chk("pre_rst_level", bus.fifo_level, 5);
      chk("pre_rst_id",    bus.active_v_id, 32'h201);
      idle_inputs();
      do_reset();
      bus.front_active_v_valid = 1'b1;
      bus.front_active_v_id    = 32'h077;
      step();
      chk("post_rst_first_wr", bus.fifo_level, 1);
      idle_inputs();
      step();
      step();

`ifdef RD_AVO_DUP_FILTER_EN
      idle_inputs();
      do_reset();
      outs.delete();
      for (int k = 0; k < 12; k++) begin
         bus.front_active_v_valid = k < 4;
         case (k)
            0, 1, 3: bus.front_active_v_id = 32'h40;
            2:       bus.front_active_v_id = 32'h41;
            default: bus.front_active_v_id = 32'h0;
         endcase
         step();
         if (bus.active_v_id_valid) outs.push_back(bus.active_v_id);
      end
      chk("dup_count", outs.size(), 3);
      if (outs.size() == 3) begin
         chk("dup_out0", outs[0], 32'h40);
         chk("dup_out1", outs[1], 32'h41);
         chk("dup_out2", outs[2], 32'h40);
      end
      chk("dup_ovf", bus.overflow_err, 0);
`endif

      // Random traffic with periodic quiet windows so end detection fires.
      idle_inputs();
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ((cyc % 400) >= 320) begin
            bus.front_active_v_valid      = 1'b0;
            bus.next_stage_full           = 1'b0;
            bus.front_iteration_end       = 1'b1;
            bus.front_iteration_end_valid = 1'b1;
         end else begin
            int pct;
            case ((cyc / 64) % 3)
               0:       pct = 10;
               1:       pct = 50;
               default: pct = 90;
            endcase
            bus.front_active_v_valid      = $urandom_range(0, 99) < 60;
            bus.next_stage_full           = $urandom_range(0, 99) < pct;
            bus.front_iteration_end       = $urandom_range(0, 3) != 0;
            bus.front_iteration_end_valid = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 49) == 0) bus.front_iteration_id = IW'($urandom);
         end
         if ($urandom_range(0, 3) == 0) bus.front_active_v_id = VW'($urandom_range(0, 3));
         else                           bus.front_active_v_id = $urandom;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
